button_debounce: RTL

- Per-button input conditioner upstream of the autofire stage.
- Takes raw controller key bits from the Pocket cont1_key bus, which are asynchronous to the core clock, and synchronises each bit.
- Filters contact bounce with a per-bit stability counter and emits clean levels plus one-cycle press/release pulses.
- Each clean level output feeds one autofire instance's btn_in.

---
 rtl/input_pkg.sv | 23 ++
 rtl/debounce_bit.sv | 114 +++++++++++
 rtl/button_debounce.sv | 36 +++
 3 files changed

// File: rtl/input_pkg.sv
// Shared types and helpers for the controller input conditioning path.
package input_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      SETTLE_HIGH = 2'd1,
      STABLE_HIGH = 2'd2,
      SETTLE_LOW  = 2'd3
   } db_state_t;

   // Stable-time in core cycles; never below one confirmation cycle.
   function automatic int unsigned calc_db_cycles(input int unsigned clk_hz, input int unsigned us);
      int unsigned cyc;
      cyc = (clk_hz / 32'd1_000_000) * us;
      if (cyc < 32'd1) begin
         cyc = 32'd1;
      end else begin
         cyc = cyc;
      end
      return cyc;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button bit: 2-FF synchroniser, settle/stable FSM with stability counter,
// registered clean level and one-cycle edge pulses.
module debounce_bit
   import input_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 1,
   parameter int unsigned CW        = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic freeze,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
   localparam logic [CW-1:0] ONE    = CW'(1);

   logic      sync1_q, sync2_q;
   db_state_t state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic      level_q, level_d;
   logic      rise_q, rise_d;
   logic      fall_q, fall_d;

   // Next-state, counter and output computation; freeze holds everything but the synchroniser.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (freeze) begin
         state_d = state_q;
      end else begin
         // Level trails the FSM by one register so pulses line up with the level change.
         level_d = (state_q == STABLE_HIGH) || (state_q == SETTLE_LOW);
         rise_d  = level_d & ~level_q;
         fall_d  = ~level_d & level_q;
         case (state_q)
            STABLE_LOW: begin
               if (sync2_q) begin
                  state_d = SETTLE_HIGH;
                  count_d = ONE;
               end else begin
                  count_d = '0;
               end
            end
            SETTLE_HIGH: begin
               if (!sync2_q) begin
                  state_d = STABLE_LOW;
                  count_d = '0;
               end else if (count_q == DB_MAX) begin
                  state_d = STABLE_HIGH;
                  count_d = '0;
               end else begin
                  count_d = count_q + ONE;
               end
            end
            STABLE_HIGH: begin
               if (!sync2_q) begin
                  state_d = SETTLE_LOW;
                  count_d = ONE;
               end else begin
                  count_d = '0;
               end
            end
            SETTLE_LOW: begin
               if (sync2_q) begin
                  state_d = STABLE_HIGH;
                  count_d = '0;
               end else if (count_q == DB_MAX) begin
                  state_d = STABLE_LOW;
                  count_d = '0;
               end else begin
                  count_d = count_q + ONE;
               end
            end
            default: begin
               state_d = STABLE_LOW;
               count_d = '0;
            end
         endcase
      end
   end

   // State, counter, synchroniser and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= STABLE_LOW;
         count_q <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         count_q <= count_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/button_debounce.sv
// Per-button debouncer for the cont1_key bus: WIDTH independent debounce_bit lanes.
module button_debounce
   import input_pkg::*;
#(
   parameter int unsigned CLK         = 12_000_000,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEBOUNCE_US = 5000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             freeze,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_rise,
   output logic [WIDTH-1:0] btn_fall
);

   localparam int unsigned DB_CYCLES = calc_db_cycles(CLK, DEBOUNCE_US);
   localparam int unsigned CW        = $clog2(DB_CYCLES + 1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DB_CYCLES (DB_CYCLES),
         .CW        (CW)
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .freeze  (freeze),
         .raw     (btn_raw[i]),
         .level   (btn_level[i]),
         .rise    (btn_rise[i]),
         .fall    (btn_fall[i])
      );
   end

endmodule
